// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider / tick-strobe generator.
// Each channel divides clk by a run-time divisor, with deferred reloads, graceful stop and global restart.
module clk_div_gen #(
  parameter int NUM_CH   = 3,
  parameter int CNT_W    = 8,
  parameter int DIV_INIT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH*CNT_W-1:0] div_in,
  input  logic [NUM_CH-1:0]       div_load,
  input  logic                    sync_restart,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       active
);

  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v < CNT_W'(2)) begin
      r = CNT_W'(2);
    end else begin
      r = v;
    end
    return r;
  endfunction

  localparam logic [CNT_W-1:0] DIV_RST = clamp_div(CNT_W'(DIV_INIT));

  logic [CNT_W-1:0]  cnt_q      [NUM_CH];
  logic [CNT_W-1:0]  cnt_d      [NUM_CH];
  logic [CNT_W-1:0]  div_q      [NUM_CH];
  logic [CNT_W-1:0]  div_d      [NUM_CH];
  logic [CNT_W-1:0]  pend_q     [NUM_CH];
  logic [CNT_W-1:0]  pend_d     [NUM_CH];
  logic [CNT_W-1:0]  din_s      [NUM_CH];
  logic [CNT_W-1:0]  next_div_s [NUM_CH];
  logic [NUM_CH-1:0] last_s;
  logic [NUM_CH-1:0] pend_v_q;
  logic [NUM_CH-1:0] pend_v_d;
  logic [NUM_CH-1:0] run_q;
  logic [NUM_CH-1:0] run_d;
  logic [NUM_CH-1:0] clk_out_q;
  logic [NUM_CH-1:0] clk_out_d;
  logic [NUM_CH-1:0] tick_q;
  logic [NUM_CH-1:0] tick_d;
  logic [NUM_CH-1:0] active_q;
  logic [NUM_CH-1:0] active_d;

  // Per-channel next-state: restart, idle and period boundary all start a fresh period.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      din_s[i]    = clamp_div(div_in[i*CNT_W +: CNT_W]);
      last_s[i]   = (cnt_q[i] == (div_q[i] - CNT_W'(1)));
      pend_d[i]   = pend_q[i];
      pend_v_d[i] = pend_v_q[i];

      // A same-cycle load wins over an older pending value.
      if (div_load[i]) begin
        next_div_s[i] = din_s[i];
      end else if (pend_v_q[i]) begin
        next_div_s[i] = pend_q[i];
      end else begin
        next_div_s[i] = div_q[i];
      end

      // A running channel with en low is draining; it only stops when its period ends.
      if (sync_restart || !run_q[i] || last_s[i]) begin
        cnt_d[i]    = {CNT_W{1'b0}};
        run_d[i]    = en[i];
        div_d[i]    = next_div_s[i];
        pend_v_d[i] = 1'b0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
        run_d[i] = 1'b1;
        div_d[i] = div_q[i];
        if (div_load[i]) begin
          pend_d[i]   = din_s[i];
          pend_v_d[i] = 1'b1;
        end else begin
          pend_d[i]   = pend_q[i];
          pend_v_d[i] = pend_v_q[i];
        end
      end

      clk_out_d[i] = run_d[i] && (cnt_d[i] < (div_d[i] >> 1));
      tick_d[i]    = run_d[i] && (cnt_d[i] == (div_d[i] - CNT_W'(1)));
      active_d[i]  = run_d[i];
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]  <= {CNT_W{1'b0}};
        div_q[i]  <= DIV_RST;
        pend_q[i] <= DIV_RST;
      end
      pend_v_q  <= {NUM_CH{1'b0}};
      run_q     <= {NUM_CH{1'b0}};
      clk_out_q <= {NUM_CH{1'b0}};
      tick_q    <= {NUM_CH{1'b0}};
      active_q  <= {NUM_CH{1'b0}};
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]  <= cnt_d[i];
        div_q[i]  <= div_d[i];
        pend_q[i] <= pend_d[i];
      end
      pend_v_q  <= pend_v_d;
      run_q     <= run_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      active_q  <= active_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign active  = active_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: directed scenarios plus a randomized run
// against a period-level reference model.
module tb_clk_div_gen;
  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  en;
  logic [23:0] div_in;
  logic [2:0]  div_load;
  logic        sync_restart;
  logic [2:0]  clk_out;
  logic [2:0]  tick;
  logic [2:0]  active;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: per channel, running flag, position within the period,
  // period length and the pending divisor (-1 when none).
  int m_run  [3];
  int m_pos  [3];
  int m_per  [3];
  int m_pend [3];

  always #5 clk = ~clk;

  clk_div_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DIV_INIT(2)) dut (
    .clk(clk), .rst(rst), .en(en), .div_in(div_in), .div_load(div_load),
    .sync_restart(sync_restart), .clk_out(clk_out), .tick(tick), .active(active)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] pack3(input int d0, input int d1, input int d2);
    return {8'(d2), 8'(d1), 8'(d0)};
  endfunction

  function automatic int clampi(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  task automatic do_reset();
    rst = 1'b1; en = 3'b000; div_load = 3'b000; sync_restart = 1'b0; div_in = 24'd0;
    step();
    rst = 1'b0;
  endtask

  task automatic load_idle(input int d0, input int d1, input int d2);
    div_in = pack3(d0, d1, d2); div_load = 3'b111; en = 3'b000;
    step();
    div_load = 3'b000;
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      int nd;
      nd = clampi(int'(div_in[i*8 +: 8]));
      if (rst) begin
        m_run[i] = 0; m_pos[i] = 0; m_per[i] = 2; m_pend[i] = -1;
      end else if (sync_restart) begin
        if (div_load[i]) m_per[i] = nd;
        else if (m_pend[i] >= 0) m_per[i] = m_pend[i];
        m_pend[i] = -1; m_pos[i] = 0; m_run[i] = en[i] ? 1 : 0;
      end else if (m_run[i] == 0) begin
        if (div_load[i]) m_per[i] = nd;
        m_pos[i] = 0; m_run[i] = en[i] ? 1 : 0;
      end else if (m_pos[i] == m_per[i] - 1) begin
        // Period complete: next period picks up newest divisor; stop if en is low.
        if (div_load[i]) m_per[i] = nd;
        else if (m_pend[i] >= 0) m_per[i] = m_pend[i];
        m_pend[i] = -1; m_pos[i] = 0; m_run[i] = en[i] ? 1 : 0;
      end else begin
        m_pos[i] = m_pos[i] + 1;
        if (div_load[i]) m_pend[i] = nd;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 3'b111; div_load = 3'b000; sync_restart = 1'b0; div_in = 24'd0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_total++;
      if ({clk_out, tick, active} !== 9'd0)
        $display("FAIL reset_hold cyc %0d: got %b expected 000000000", k, {clk_out, tick, active});
      else n_pass++;
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic [2:0] ec;
      step();
      ec = (k % 2 == 0) ? 3'b111 : 3'b000;
      n_total++;
      if (clk_out !== ec || tick !== ~ec || active !== 3'b111)
        $display("FAIL reset_release cyc %0d: got clk=%b tick=%b act=%b expected clk=%b tick=%b act=111",
                 k, clk_out, tick, active, ec, ~ec);
      else n_pass++;
    end
  endtask

  task automatic test_rate();
    int ticks [3];
    int highs [3];
    do_reset();
    load_idle(2, 4, 8);
    en = 3'b111;
    step();
    n_total++;
    if (clk_out !== 3'b111) $display("FAIL rate_align: got %b expected 111", clk_out);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin ticks[i] = 0; highs[i] = 0; end
    for (int k = 0; k < 80; k++) begin
      for (int i = 0; i < 3; i++) begin
        ticks[i] += int'(tick[i]);
        highs[i] += int'(clk_out[i]);
      end
      step();
    end
    n_total++;
    if (ticks[0] != 40 || ticks[1] != 20 || ticks[2] != 10)
      $display("FAIL rate_ticks: got %0d/%0d/%0d expected 40/20/10", ticks[0], ticks[1], ticks[2]);
    else n_pass++;
    n_total++;
    if (highs[0] != 40 || highs[1] != 40 || highs[2] != 40)
      $display("FAIL rate_high: got %0d/%0d/%0d expected 40/40/40", highs[0], highs[1], highs[2]);
    else n_pass++;
  endtask

  task automatic test_odd_clamp();
    do_reset();
    load_idle(3, 0, 1);
    en = 3'b111;
    step();
    for (int k = 0; k < 6; k++) begin
      logic [2:0] ec, et;
      ec = {(k % 2 == 0), (k % 2 == 0), (k % 3 == 0)};
      et = {(k % 2 == 1), (k % 2 == 1), (k % 3 == 2)};
      n_total++;
      if (clk_out !== ec || tick !== et)
        $display("FAIL odd_clamp cyc %0d: got clk=%b tick=%b expected clk=%b tick=%b", k, clk_out, tick, ec, et);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_deferred();
    logic [14:0] exp_clk;
    logic [14:0] exp_tick;
    exp_clk  = 15'b001001000110011;
    exp_tick = 15'b100100100001000;
    do_reset();
    load_idle(4, 2, 2);
    en = 3'b001;
    step();
    for (int k = 0; k < 15; k++) begin
      n_total++;
      if (clk_out !== {2'b00, exp_clk[k]} || tick !== {2'b00, exp_tick[k]})
        $display("FAIL deferred cyc %0d: got clk=%b tick=%b expected clk=00%b tick=00%b",
                 k, clk_out, tick, exp_clk[k], exp_tick[k]);
      else n_pass++;
      div_load = 3'b000;
      if (k == 1) begin div_load = 3'b001; div_in = pack3(6, 0, 0); end
      if (k == 2) begin div_load = 3'b001; div_in = pack3(5, 0, 0); end
      if (k == 8) begin div_load = 3'b001; div_in = pack3(3, 0, 0); end
      step();
    end
    div_load = 3'b000;
  endtask

  task automatic test_drain();
    do_reset();
    load_idle(8, 2, 2);
    en = 3'b001;
    step();
    for (int k = 0; k < 10; k++) begin
      logic ea, et, ec;
      ea = (k <= 7); et = (k == 7); ec = (k <= 3);
      n_total++;
      if (active !== {2'b00, ea} || tick !== {2'b00, et} || clk_out !== {2'b00, ec})
        $display("FAIL drain_stop cyc %0d: got act=%b tick=%b clk=%b expected act=00%b tick=00%b clk=00%b",
                 k, active, tick, clk_out, ea, et, ec);
      else n_pass++;
      en = (k < 2) ? 3'b001 : 3'b000;
      step();
    end
    do_reset();
    load_idle(8, 2, 2);
    en = 3'b001;
    step();
    for (int k = 0; k < 18; k++) begin
      logic et, ec;
      et = (k == 7 || k == 15); ec = ((k % 8) < 4);
      n_total++;
      if (active !== 3'b001 || tick !== {2'b00, et} || clk_out !== {2'b00, ec})
        $display("FAIL drain_cancel cyc %0d: got act=%b tick=%b clk=%b expected act=001 tick=00%b clk=00%b",
                 k, active, tick, clk_out, et, ec);
      else n_pass++;
      en = (k < 2 || k >= 5) ? 3'b001 : 3'b000;
      step();
    end
  endtask

  task automatic test_restart();
    logic [2:0] ecs [3];
    logic [2:0] ets [3];
    ecs[0] = 3'b011; ecs[1] = 3'b000; ecs[2] = 3'b001;
    ets[0] = 3'b000; ets[1] = 3'b001; ets[2] = 3'b010;
    do_reset();
    load_idle(5, 7, 4);
    en = 3'b111;
    step();
    repeat ($urandom_range(3, 10)) step();
    div_load = 3'b001; div_in = pack3(2, 0, 0);
    step();
    div_load = 3'b000; en = 3'b011;
    step();
    sync_restart = 1'b1; div_load = 3'b010; div_in = pack3(0, 3, 0);
    step();
    sync_restart = 1'b0; div_load = 3'b000;
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (active !== 3'b011 || clk_out !== ecs[k] || tick !== ets[k])
        $display("FAIL restart cyc %0d: got act=%b clk=%b tick=%b expected act=011 clk=%b tick=%b",
                 k, active, clk_out, tick, ecs[k], ets[k]);
      else n_pass++;
      step();
    end
    en = 3'b111; div_load = 3'b010; div_in = pack3(0, 9, 0);
    step();
    div_load = 3'b000; rst = 1'b1;
    step();
    n_total++;
    if ({clk_out, tick, active} !== 9'd0)
      $display("FAIL midrun_reset: got %b expected 000000000", {clk_out, tick, active});
    else n_pass++;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      logic [2:0] ec;
      step();
      ec = (k % 2 == 0) ? 3'b111 : 3'b000;
      n_total++;
      if (clk_out !== ec || tick !== ~ec)
        $display("FAIL reset_discard cyc %0d: got clk=%b tick=%b expected clk=%b tick=%b", k, clk_out, tick, ec, ~ec);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    rst = 1'b1; en = 3'b000; div_load = 3'b000; sync_restart = 1'b0; div_in = 24'd0;
    @(posedge clk); model_step(); #1;
    rst = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      logic [2:0] ec, et, ea;
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 15) == 0) en[i] = ~en[i];
        div_load[i] = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 7) == 0) div_in[i*8 +: 8] = 8'($urandom_range(0, 255));
        else div_in[i*8 +: 8] = 8'($urandom_range(0, 9));
      end
      sync_restart = ($urandom_range(0, 63) == 0);
      rst = ($urandom_range(0, 299) == 0);
      @(posedge clk);
      model_step();
      #1;
      for (int i = 0; i < 3; i++) begin
        ea[i] = (m_run[i] != 0);
        ec[i] = ea[i] && (m_pos[i] < m_per[i] / 2);
        et[i] = ea[i] && (m_pos[i] == m_per[i] - 1);
      end
      n_total++;
      if (clk_out !== ec) $display("FAIL rand_clk_out cyc %0d: got %b expected %b", c, clk_out, ec);
      else n_pass++;
      n_total++;
      if (tick !== et) $display("FAIL rand_tick cyc %0d: got %b expected %b", c, tick, et);
      else n_pass++;
      n_total++;
      if (active !== ea) $display("FAIL rand_active cyc %0d: got %b expected %b", c, active, ea);
      else n_pass++;
    end
    rst = 1'b0; sync_restart = 1'b0; div_load = 3'b000;
  endtask

  initial begin
    test_reset();
    test_rate();
    test_odd_clamp();
    test_deferred();
    test_drain();
    test_restart();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
